// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction queue feeding a registered MIPS main decoder
// Optional CP0 decode (mtc0/mfc0/eret) is enabled by defining DECODE_CP0_EN.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [31:0]     inst_out,
    output logic [PC_W-1:0] pc_out,
    output logic [19:0]     ctrl_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [31:0]     inst_mem_q [DEPTH];
    logic [PC_W-1:0] pc_mem_q   [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    logic            out_valid_q;
    logic [31:0]     inst_out_q;
    logic [PC_W-1:0] pc_out_q;
    logic [19:0]     ctrl_q;
    logic            delay_q, delay_d;

    logic            push, load;
    logic [31:0]     head_inst;
    logic [5:0]      op, funct;
    logic [4:0]      rt;

    logic regwrite, regdst, alusrc, branch, mem_en, mem_wr;
    logic [1:0] memtoreg;
    logic gprtohi, gprtolo, jump, jumpr, write_al, al_inst;
    logic cp0write, is_syscall, is_break, is_eret, ri;

    assign inst_ready = (count_q < DEPTH_C);
    assign push       = inst_valid && inst_ready && !flush;
    assign load       = (count_q != '0) && (!out_valid_q || out_ready) && !flush;

    assign head_inst = inst_mem_q[rd_ptr_q];
    assign op        = head_inst[31:26];
    assign rt        = head_inst[20:16];
    assign funct     = head_inst[5:0];

    always_comb begin
        regwrite   = 1'b0;
        regdst     = 1'b0;
        alusrc     = 1'b0;
        branch     = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        memtoreg   = 2'b00;
        gprtohi    = 1'b0;
        gprtolo    = 1'b0;
        jump       = 1'b0;
        jumpr      = 1'b0;
        write_al   = 1'b0;
        al_inst    = 1'b0;
        cp0write   = 1'b0;
        is_syscall = 1'b0;
        is_break   = 1'b0;
        is_eret    = 1'b0;
        ri         = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                        gprtohi  = 1'b1;
                        gprtolo  = 1'b1;
                    end
                    6'h10: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                        memtoreg = 2'b10;
                    end
                    6'h12: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                        memtoreg = 2'b11;
                    end
                    6'h11: gprtohi    = 1'b1;
                    6'h13: gprtolo    = 1'b1;
                    6'h0C: is_syscall = 1'b1;
                    6'h0D: is_break   = 1'b1;
                    6'h08: jumpr      = 1'b1;
                    6'h09: begin
                        jumpr    = 1'b1;
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                        al_inst  = 1'b1;
                    end
                    default: ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'b00000, 5'b00001: begin
                        branch = 1'b1;
                        alusrc = 1'b1;
                    end
                    5'b10000, 5'b10001: begin
                        branch   = 1'b1;
                        alusrc   = 1'b1;
                        regwrite = 1'b1;
                        al_inst  = 1'b1;
                        write_al = 1'b1;
                    end
                    default: ri = 1'b1;
                endcase
            end
            6'h02: jump = 1'b1;
            6'h03: begin
                jump     = 1'b1;
                regwrite = 1'b1;
                al_inst  = 1'b1;
                write_al = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: branch = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                mem_en   = 1'b1;
                memtoreg = 2'b01;
            end
            6'h28, 6'h29, 6'h2B: begin
                alusrc = 1'b1;
                mem_en = 1'b1;
                mem_wr = 1'b1;
            end
`ifdef DECODE_CP0_EN
            6'h10: begin
                case (head_inst[25:21])
                    5'b00100: cp0write = 1'b1;
                    5'b00000: regwrite = 1'b1;
                    5'b10000: is_eret  = 1'b1;
                    default:  ri       = 1'b1;
                endcase
            end
`endif
            default: ri = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        delay_d  = delay_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            delay_d  = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (load) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                // Any control transfer arms the flag for the following instruction.
                delay_d  = branch | jump | jumpr;
            end
            case ({push, load})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= inst_in;
            pc_mem_q[wr_ptr_q]   <= pc_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            delay_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            delay_q  <= delay_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            inst_out_q  <= '0;
            pc_out_q    <= '0;
            ctrl_q      <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            inst_out_q  <= head_inst;
            pc_out_q    <= pc_mem_q[rd_ptr_q];
            ctrl_q      <= {regwrite, regdst, alusrc, branch, mem_en, mem_wr, memtoreg,
                            gprtohi, gprtolo, jump, jumpr, write_al, al_inst, cp0write,
                            is_syscall, is_break, is_eret, ri, delay_q};
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign inst_out  = inst_out_q;
    assign pc_out    = pc_out_q;
    assign ctrl_out  = ctrl_q;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst_in = '0;
    logic [31:0] pc_in = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [19:0] ctrl_out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [19:0] C_ALU_R  = 20'hC0000;
    localparam logic [19:0] C_BEQ    = 20'h10000;
    localparam logic [19:0] C_LW_DS  = 20'hA9001;
    localparam logic [19:0] C_BGEZAL = 20'hB00C0;
    localparam logic [19:0] C_SW_DS  = 20'h2C001;
    localparam logic [19:0] C_RI     = 20'h00002;
`ifdef DECODE_CP0_EN
    localparam logic [19:0] C_ERET   = 20'h00004;
`else
    localparam logic [19:0] C_ERET   = 20'h00002;
`endif

    decode_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_in    (inst_in),
        .pc_in      (pc_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .ctrl_out   (ctrl_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        inst_valid = 1'b1;
        inst_in    = inst;
        pc_in      = pc;
        step();
        inst_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_inst_out", inst_out, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_ctrl_out", ctrl_out, 0);
        step();
        step();
        rst = 1'b0;
        check("rst_inst_ready", inst_ready, 1);

        // single add, one-cycle load latency
        out_ready = 1'b1;
        push(32'h00851020, 32'hBFC00000);
        check("add_not_yet_valid", out_valid, 0);
        step();
        check("add_valid", out_valid, 1);
        check("add_ctrl", ctrl_out, C_ALU_R);
        check("add_pc", pc_out, 32'hBFC00000);
        check("add_inst", inst_out, 32'h00851020);
        step();
        check("add_drained", out_valid, 0);

        // backpressure: five pushes with out_ready low
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_ready_before_push", inst_ready, 1);
            push(32'h00000021 | (k << 11), 32'h100 + 4 * k);
        end
        check("bp_full_ready", inst_ready, 0);
        check("bp_head_valid", out_valid, 1);
        check("bp_head_inst", inst_out, 32'h00000021);
        step();
        step();
        check("bp_hold_inst", inst_out, 32'h00000021);
        check("bp_hold_pc", pc_out, 32'h100);
        check("bp_hold_ready", inst_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_inst", inst_out, 32'h00000021 | (k << 11));
            check("drain_pc", pc_out, 32'h100 + 4 * k);
            check("drain_ctrl", ctrl_out, C_ALU_R);
            step();
        end
        check("drain_empty", out_valid, 0);

        // bgezal then sw back to back
        push(32'h04110005, 32'h300);
        push(32'hAC430004, 32'h304);
        check("bgezal_inst", inst_out, 32'h04110005);
        check("bgezal_ctrl", ctrl_out, C_BGEZAL);
        step();
        check("sw_ds_ctrl", ctrl_out, C_SW_DS);
        check("sw_ds_pc", pc_out, 32'h304);
        step();
        check("sw_drained", out_valid, 0);

        // beq then lw in delay slot
        push(32'h10220003, 32'h400);
        push(32'h8C430004, 32'h404);
        check("beq_ctrl", ctrl_out, C_BEQ);
        step();
        check("lw_ds_ctrl", ctrl_out, C_LW_DS);
        step();
        check("lw_drained", out_valid, 0);

        // flush with a pending delay slot and three queued entries
        out_ready = 1'b0;
        push(32'h10220003, 32'h500);
        push(32'h00000021, 32'h504);
        push(32'h00000821, 32'h508);
        push(32'h00001021, 32'h50C);
        check("pre_flush_inst", inst_out, 32'h10220003);
        check("pre_flush_count", dut.count_q, 3);
        flush      = 1'b1;
        inst_valid = 1'b1;
        inst_in    = 32'h00001821;
        pc_in      = 32'h510;
        step();
        flush      = 1'b0;
        inst_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_inst_ready", inst_ready, 1);
        check("flush_count", dut.count_q, 0);
        step();
        check("flush_push_dropped", out_valid, 0);
        out_ready = 1'b1;
        push(32'h00851020, 32'h600);
        step();
        check("post_flush_valid", out_valid, 1);
        check("post_flush_inst", inst_out, 32'h00851020);
        check("post_flush_ctrl", ctrl_out, C_ALU_R);
        step();

        // reserved instruction
        push(32'hFC000000, 32'h700);
        step();
        check("ri_valid", out_valid, 1);
        check("ri_ctrl", ctrl_out, C_RI);
        step();

        // eret
        push(32'h42000018, 32'h704);
        step();
        check("eret_ctrl", ctrl_out, C_ERET);
        step();
        check("final_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
